// File: rtl/rddata_align.sv
// Read-data alignment stage for the dpsram_block_4x512x20 read path: extracts and right-justifies the addressed slice.
// Define RDDATA_ALIGN_OUTREG_EN to add an extra output register stage (latency 3 instead of 2).
module rddata_align (
   input  logic        clk_i,
   input  logic        rstn_i,
   input  logic [2:0]  output_config_i,
   input  logic        rd_en_i,
   input  logic [4:0]  rd_sel_i,
   input  logic [19:0] rddata_i,
   output logic [19:0] aligned_rddata_o,
   output logic        rd_valid_o,
   output logic        sel_err_o
);

   localparam logic [2:0] CONFIG_1BIT  = 3'd1;
   localparam logic [2:0] CONFIG_2BIT  = 3'd2;
   localparam logic [2:0] CONFIG_5BIT  = 3'd3;
   localparam logic [2:0] CONFIG_10BIT = 3'd4;
   localparam logic [2:0] CONFIG_20BIT = 3'd5;
   localparam logic [2:0] CONFIG_40BIT = 3'd6;
   localparam logic [2:0] CONFIG_80BIT = 3'd7;

   logic [2:0]  cfg_q;
   logic [4:0]  sel_q;
   logic        pend_q;

   logic [19:0] data_q;
   logic        valid_q;
   logic        err_q;

   logic [19:0] slice_mask;
   logic [4:0]  slice_count;
   logic [4:0]  bit_offset;
   logic        pass_thru;
   logic [19:0] align_data;
   logic        align_err;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         cfg_q  <= 3'd0;
         sel_q  <= 5'd0;
         pend_q <= 1'b0;
      end else begin
         pend_q <= rd_en_i;
         if (rd_en_i) begin
            cfg_q <= output_config_i;
            sel_q <= rd_sel_i;
         end
      end
   end

   // Offsets are only used when sel_q is in range, so narrow arithmetic cannot overflow.
   always_comb begin
      slice_mask  = 20'hFFFFF;
      slice_count = 5'd1;
      bit_offset  = 5'd0;
      pass_thru   = 1'b1;
      unique case (cfg_q)
         CONFIG_1BIT: begin
            slice_mask  = 20'h00001;
            slice_count = 5'd20;
            bit_offset  = sel_q;
            pass_thru   = 1'b0;
         end
         CONFIG_2BIT: begin
            slice_mask  = 20'h00003;
            slice_count = 5'd10;
            bit_offset  = {sel_q[3:0], 1'b0};
            pass_thru   = 1'b0;
         end
         CONFIG_5BIT: begin
            slice_mask  = 20'h0001F;
            slice_count = 5'd4;
            bit_offset  = {sel_q[2:0], 2'b00} + {2'b00, sel_q[2:0]};
            pass_thru   = 1'b0;
         end
         CONFIG_10BIT: begin
            slice_mask  = 20'h003FF;
            slice_count = 5'd2;
            bit_offset  = sel_q[0] ? 5'd10 : 5'd0;
            pass_thru   = 1'b0;
         end
         CONFIG_20BIT, CONFIG_40BIT, CONFIG_80BIT: begin
            pass_thru   = 1'b1;
         end
         default: begin
            pass_thru   = 1'b1;
         end
      endcase
   end

   always_comb begin
      align_data = rddata_i;
      align_err  = 1'b0;
      if (!pass_thru) begin
         if (sel_q < slice_count) begin
            align_data = (rddata_i >> bit_offset) & slice_mask;
         end else begin
            align_data = 20'h00000;
            align_err  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         data_q  <= 20'h00000;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         valid_q <= pend_q;
         err_q   <= pend_q & align_err;
         if (pend_q) begin
            data_q <= align_data;
         end
      end
   end

`ifdef RDDATA_ALIGN_OUTREG_EN
   logic [19:0] data_oq;
   logic        valid_oq;
   logic        err_oq;

   // Retiming stage: holds data while idle so the downstream mux sees a stable value.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         data_oq  <= 20'h00000;
         valid_oq <= 1'b0;
         err_oq   <= 1'b0;
      end else begin
         valid_oq <= valid_q;
         err_oq   <= err_q;
         if (valid_q) begin
            data_oq <= data_q;
         end
      end
   end

   assign aligned_rddata_o = data_oq;
   assign rd_valid_o       = valid_oq;
   assign sel_err_o        = err_oq;
`else
   assign aligned_rddata_o = data_q;
   assign rd_valid_o       = valid_q;
   assign sel_err_o        = err_q;
`endif

endmodule
